// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/div into HI/LO with busy/start for stalls.
// Divider datapath is compiled in only when MDU_DIV_EN is defined.
//
// state | meaning
// IDLE  | no op in flight; accepts mult/div/mthi/mtlo
// RUN   | op in flight; cnt counts down, commit to HI/LO when cnt == 1
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] e_rd1,
  input  logic [31:0] e_rd2,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic          pend_wr, pend_wr_n;
  logic [31:0]   hi_n, lo_n;

  logic          is_mul, is_div;
  logic [63:0]   prod_u, prod_s, prod;

  assign is_mul = (mdu_op == 3'd1) || (mdu_op == 3'd2);
  assign start  = is_mul || is_div;
  assign busy   = (state == RUN);

  assign prod_u = {32'd0, e_rd1} * {32'd0, e_rd2};
  assign prod_s = $signed({{32{e_rd1[31]}}, e_rd1}) * $signed({{32{e_rd2[31]}}, e_rd2});
  assign prod   = (mdu_op == 3'd1) ? prod_s : prod_u;

`ifdef MDU_DIV_EN
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);

  logic        div_signed, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign is_div     = (mdu_op == 3'd3) || (mdu_op == 3'd4);
  assign div_signed = (mdu_op == 3'd3);
  assign a_neg      = div_signed & e_rd1[31];
  assign b_neg      = div_signed & e_rd2[31];
  assign a_mag      = a_neg ? (~e_rd1 + 32'd1) : e_rd1;
  assign b_mag      = b_neg ? (~e_rd2 + 32'd1) : e_rd2;
  assign div_zero   = (e_rd2 == 32'd0);
  // Magnitude divide keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  assign b_safe     = div_zero ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
`else
  assign is_div = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    hi_n      = hi;
    lo_n      = lo;
    case (state)
      IDLE: begin
        if (is_mul) begin
          state_n   = RUN;
          cnt_n     = MULT_LOAD;
          pend_hi_n = prod[63:32];
          pend_lo_n = prod[31:0];
          pend_wr_n = 1'b1;
        end
`ifdef MDU_DIV_EN
        else if (is_div) begin
          state_n   = RUN;
          cnt_n     = DIV_LOAD;
          pend_hi_n = rem;
          pend_lo_n = quo;
          pend_wr_n = ~div_zero;
        end
`endif
        else if (mdu_op == 3'd5) begin
          hi_n = e_rd1;
        end else if (mdu_op == 3'd6) begin
          lo_n = e_rd1;
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = IDLE;
          if (pend_wr) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
      hi      <= hi_n;
      lo      <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver pushes expected commits/register states, monitor compares.
// Expectations for div/divu follow MDU_DIV_EN, matching the build of the design.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mdu_op;
  logic [31:0] e_rd1, e_rd2;
  logic        start, busy;
  logic [31:0] hi, lo;

  mdu dut (
    .clk(clk), .reset(reset), .mdu_op(mdu_op), .e_rd1(e_rd1), .e_rd2(e_rd2),
    .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_len;
  } op_t;

  typedef struct {
    string       name;
    int          due;
    logic        is_start;
    logic        exp_start;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_busy;
  } imm_t;

  op_t  op_q[$];
  imm_t imm_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkint(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: busy falling edge presents a committed result; timed items check register state.
  initial begin : monitor
    int   run_len;
    logic prev_busy;
    op_t  o;
    run_len = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) begin
        run_len++;
      end else begin
        if (prev_busy) begin
          if (op_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit: busy fell at cycle %0d with nothing expected", cyc);
          end else begin
            o = op_q.pop_front();
            chkint({o.name, "_busy_len"}, run_len, o.exp_len);
            chk32({o.name, "_hi"}, hi, o.exp_hi);
            chk32({o.name, "_lo"}, lo, o.exp_lo);
          end
        end
        run_len = 0;
      end
      prev_busy = (busy === 1'b1);
      for (int i = imm_q.size() - 1; i >= 0; i--) begin
        if (imm_q[i].due == cyc) begin
          if (imm_q[i].is_start) begin
            chk32({imm_q[i].name, "_start"}, {31'd0, start}, {31'd0, imm_q[i].exp_start});
          end else begin
            chk32({imm_q[i].name, "_busy"}, {31'd0, busy}, {31'd0, imm_q[i].exp_busy});
            chk32({imm_q[i].name, "_hi"}, hi, imm_q[i].exp_hi);
            chk32({imm_q[i].name, "_lo"}, lo, imm_q[i].exp_lo);
          end
          imm_q.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // off=1: the current cycle; off=2: the cycle after the next edge.
  task automatic push_regs(string name, int off, logic [31:0] h, logic [31:0] l, logic b);
    imm_t it;
    it.name = name; it.due = cyc + off; it.is_start = 1'b0; it.exp_start = 1'b0;
    it.exp_hi = h; it.exp_lo = l; it.exp_busy = b;
    imm_q.push_back(it);
  endtask

  task automatic push_start(string name, logic s);
    imm_t it;
    it.name = name; it.due = cyc + 1; it.is_start = 1'b1; it.exp_start = s;
    it.exp_hi = '0; it.exp_lo = '0; it.exp_busy = 1'b0;
    imm_q.push_back(it);
  endtask

  task automatic push_op(string name, logic [31:0] h, logic [31:0] l, int len);
    op_t o;
    o.name = name; o.exp_hi = h; o.exp_lo = l; o.exp_len = len;
    op_q.push_back(o);
  endtask

  task automatic run_op(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] h, logic [31:0] l, int len);
    mdu_op = op; e_rd1 = a; e_rd2 = b;
    push_start(name, 1'b1);
    push_op(name, h, l, len);
    step();
    mdu_op = 3'd0; e_rd1 = '0; e_rd2 = '0;
    repeat (len) step();
    m_hi = h; m_lo = l;
  endtask

  task automatic move_to(string name, logic [2:0] op, logic [31:0] a);
    mdu_op = op; e_rd1 = a;
    push_start(name, 1'b0);
    if (op == 3'd5) m_hi = a; else m_lo = a;
    push_regs(name, 2, m_hi, m_lo, 1'b0);
    step();
    mdu_op = 3'd0; e_rd1 = '0;
  endtask

  initial begin : driver
    reset = 1'b1; mdu_op = 3'd0; e_rd1 = '0; e_rd2 = '0;
    m_hi = '0; m_lo = '0;
    step();
    reset = 1'b0;
    push_regs("reset", 1, 32'h0, 32'h0, 1'b0);
    step();

    move_to("mtlo", 3'd6, 32'h12345678);
    move_to("mthi", 3'd5, 32'hCAFEF00D);
    step();

    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5);

    // Issue while busy: mthi and a second mult must both be dropped.
    mdu_op = 3'd1; e_rd1 = 32'h00010000; e_rd2 = 32'h00010000;
    push_start("busy_mult", 1'b1);
    push_op("busy_mult", 32'h00000001, 32'h00000000, 5);
    step();
    mdu_op = 3'd5; e_rd1 = 32'hDEADBEEF; e_rd2 = '0;
    push_regs("ignored_mthi", 2, m_hi, m_lo, 1'b1);
    step();
    mdu_op = 3'd1; e_rd1 = 32'h3; e_rd2 = 32'h3;
    push_start("ignored_mult", 1'b1);
    step();
    mdu_op = 3'd0; e_rd1 = '0; e_rd2 = '0;
    repeat (3) step();
    m_hi = 32'h1; m_lo = 32'h0;
    push_regs("after_busy_ops", 1, m_hi, m_lo, 1'b0);
    step();

`ifdef MDU_DIV_EN
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    run_op("divu_zero", 3'd4, 32'h00000007, 32'h00000000, m_hi, m_lo, 10);
    run_op("divu", 3'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10);
    mdu_op = 3'd3; e_rd1 = 32'd100; e_rd2 = 32'd7;
`else
    mdu_op = 3'd3; e_rd1 = 32'd10; e_rd2 = 32'd3;
    push_start("div_disabled", 1'b0);
    push_regs("div_disabled", 2, m_hi, m_lo, 1'b0);
    step();
    mdu_op = 3'd4;
    push_start("divu_disabled", 1'b0);
    step();
    mdu_op = 3'd0; e_rd1 = '0; e_rd2 = '0;
    repeat (11) step();
    push_regs("div_disabled_late", 1, m_hi, m_lo, 1'b0);
    step();
    mdu_op = 3'd1; e_rd1 = 32'd100; e_rd2 = 32'd7;
`endif
    // Reset in the third busy cycle aborts the op.
    push_start("abort", 1'b1);
    push_op("abort", 32'h0, 32'h0, 3);
    step();
    mdu_op = 3'd0; e_rd1 = '0; e_rd2 = '0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    push_regs("abort_now", 1, m_hi, m_lo, 1'b0);
    repeat (12) step();
    push_regs("abort_no_commit", 1, m_hi, m_lo, 1'b0);
    step();

    run_op("mult_post", 3'd1, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5);
    run_op("multu_post", 3'd2, 32'h00000007, 32'hFFFFFFFF, 32'h00000006, 32'hFFFFFFF9, 5);
    step();

    for (int i = 0; i < 50 && (op_q.size() != 0 || imm_q.size() != 0); i++) step();
    if (op_q.size() != 0 || imm_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d ops and %0d timed items still pending, expected 0",
               op_q.size(), imm_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
